// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, sent as start, data (LSB first), optional parity and stop bits.
// oTx goes low one clock after acceptance; oReady is high only while idle, so iValid/iData are ignored mid-frame.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic                 iTick16x,
  input  logic [DATA_BITS-1:0] iData,
  input  logic                 iValid,
  output logic                 oReady,
  output logic                 oTx,
  output logic                 oBusy,
  output logic                 oDone
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : gBadParams
    $error("uart_tx: unsupported DATA_BITS/PARITY/STOP_BITS combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } stateT;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD_PAR   = (PARITY == 1);

  stateT                state;
  logic [3:0]           tickCnt;
  logic [2:0]           bitCnt;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityBit;
  logic                 bitEnd;

  assign bitEnd = iTick16x && (tickCnt == 4'd15);
  assign oBusy  = ~oReady;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state     <= IDLE;
      oTx       <= 1'b1;
      oReady    <= 1'b1;
      oDone     <= 1'b0;
      tickCnt   <= 4'd0;
      bitCnt    <= 3'd0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
    end else begin
      oDone <= 1'b0;
      // The 4-bit counter wraps to 0 on the tick that ends a bit.
      if (state != IDLE && iTick16x) tickCnt <= tickCnt + 4'd1;

      case (state)
        IDLE: begin
          if (iValid) begin
            shiftReg  <= iData;
            parityBit <= (^iData) ^ ODD_PAR;
            tickCnt   <= 4'd0;
            bitCnt    <= 3'd0;
            oTx       <= 1'b0;
            oReady    <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            oTx   <= shiftReg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bitEnd) begin
            shiftReg <= shiftReg >> 1;
            if (bitCnt == LAST_DATA) begin
              bitCnt <= 3'd0;
              if (PARITY != 0) begin
                oTx   <= parityBit;
                state <= PAR;
              end else begin
                oTx   <= 1'b1;
                state <= STOP;
              end
            end else begin
              bitCnt <= bitCnt + 3'd1;
              oTx    <= shiftReg[1];
            end
          end
        end
        PAR: begin
          if (bitEnd) begin
            oTx   <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (bitEnd) begin
            if (bitCnt == LAST_STOP) begin
              bitCnt <= 3'd0;
              oDone  <= 1'b1;
              oReady <= 1'b1;
              state  <= IDLE;
            end else begin
              bitCnt <= bitCnt + 3'd1;
            end
          end
        end
        default: begin
          oTx    <= 1'b1;
          oReady <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx: three parameterisations driven from a shared tick, checked against a bit-list frame model.
module tb_uart_tx;

  logic       iClk = 1'b0;
  logic       iRstn;
  logic       iTick16x = 1'b0;
  logic       tickEn = 1'b0;
  logic       tickFixed = 1'b0;
  int         tickGap = 0;
  logic [2:0] valid;
  logic [7:0] dataA, dataC;
  logic [6:0] dataB;
  logic       readyA, txA, busyA, doneA;
  logic       readyB, txB, busyB, doneB;
  logic       readyC, txC, busyC, doneC;

  int nCmp = 0;
  int nBad = 0;
  bit expQ[$];

  always #5 iClk = ~iClk;

  always @(posedge iClk) begin
    #1;
    if (!tickEn) iTick16x = 1'b0;
    else if (tickGap == 0) begin
      iTick16x = 1'b1;
      tickGap  = tickFixed ? 3 : int'($urandom_range(0, 3));
    end else begin
      iTick16x = 1'b0;
      tickGap  = tickGap - 1;
    end
  end

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dutA (
    .iClk(iClk), .iRstn(iRstn), .iTick16x(iTick16x), .iData(dataA), .iValid(valid[0]),
    .oReady(readyA), .oTx(txA), .oBusy(busyA), .oDone(doneA));
  uart_tx #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dutB (
    .iClk(iClk), .iRstn(iRstn), .iTick16x(iTick16x), .iData(dataB), .iValid(valid[1]),
    .oReady(readyB), .oTx(txB), .oBusy(busyB), .oDone(doneB));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dutC (
    .iClk(iClk), .iRstn(iRstn), .iTick16x(iTick16x), .iData(dataC), .iValid(valid[2]),
    .oReady(readyC), .oTx(txC), .oBusy(busyC), .oDone(doneC));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic getTx(input int inst);
    case (inst) 0: return txA; 1: return txB; default: return txC; endcase
  endfunction
  function automatic logic getReady(input int inst);
    case (inst) 0: return readyA; 1: return readyB; default: return readyC; endcase
  endfunction
  function automatic logic getBusy(input int inst);
    case (inst) 0: return busyA; 1: return busyB; default: return busyC; endcase
  endfunction
  function automatic logic getDone(input int inst);
    case (inst) 0: return doneA; 1: return doneB; default: return doneC; endcase
  endfunction

  task automatic setData(input int inst, input logic [7:0] d);
    case (inst)
      0: dataA = d;
      1: dataB = d[6:0];
      default: dataC = d;
    endcase
  endtask

  // Frame model: list of line levels, one entry per bit time.
  task automatic buildFrame(input int inst, input logic [7:0] d);
    int nb, par, nstop, ones;
    nb    = (inst == 1) ? 7 : 8;
    par   = (inst == 1) ? 2 : (inst == 2) ? 1 : 0;
    nstop = (inst == 1) ? 2 : 1;
    ones  = 0;
    expQ.delete();
    expQ.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      expQ.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par == 2) expQ.push_back(bit'(ones % 2));
    if (par == 1) expQ.push_back(bit'(1 - ones % 2));
    for (int s = 0; s < nstop; s++) expQ.push_back(1'b1);
  endtask

  task automatic startWord(input int inst, input logic [7:0] d);
    int n = 0;
    while (!getReady(inst) && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    checkEq("readyBeforeSend", getReady(inst), 1);
    setData(inst, d);
    valid[inst] = 1'b1;
  endtask

  // Called at the negedge before the accepting edge; returns at a negedge with the block idle
  // (or, with hold set, with the next word already presented).
  task automatic checkFrame(input int inst, input logic [7:0] d, input bit hold,
                            input logic [7:0] nextD, input int pauseBit);
    int total, got, budget, b;
    logic bv, s;
    bit bs, doneSeen, pauseOk;
    buildFrame(inst, d);
    total = 16 * expQ.size();
    got = 0; budget = 0; doneSeen = 0; bv = 1'b0; bs = 1'b1;
    @(negedge iClk);
    if (hold) setData(inst, nextD);
    else begin
      valid[inst] = 1'b0;
      setData(inst, 8'($urandom));
    end
    checkEq("startLatency", getTx(inst), 0);
    checkEq("busyAfterAccept", {getBusy(inst), getReady(inst)}, 2'b10);
    checkEq("doneLowAtStart", getDone(inst), 0);
    while (got < total && budget < 20000) begin
      if (getDone(inst)) doneSeen = 1;
      if (iTick16x) begin
        b = got / 16;
        s = getTx(inst);
        if (got % 16 == 0) begin
          bv = s;
          bs = 1;
          if (!hold) setData(inst, 8'($urandom));
        end else if (s !== bv) bs = 0;
        got++;
        if (got % 16 == 0)
          checkEq($sformatf("inst%0d bit%0d", inst, b), {bs, bv}, {1'b1, expQ[b]});
        if (b == pauseBit && got % 16 == 8) begin
          tickEn  = 1'b0;
          pauseOk = 1;
          for (int i = 0; i < 30; i++) begin
            @(negedge iClk);
            if (getTx(inst) !== bv || iTick16x) pauseOk = 0;
          end
          checkEq("holdWithoutTicks", pauseOk, 1);
          tickEn = 1'b1;
        end
      end
      if (got < total) begin
        @(negedge iClk);
        budget++;
      end
    end
    checkEq("frameInBudget", budget < 20000, 1);
    checkEq("noEarlyDone", doneSeen, 0);
    @(negedge iClk);
    checkEq("doneAtLastStop", getDone(inst), 1);
    checkEq("readyAtLastStop", getReady(inst), 1);
    checkEq("txIdleAfterFrame", getTx(inst), 1);
    if (!hold) begin
      @(negedge iClk);
      checkEq("donePulseWidth", getDone(inst), 0);
    end
  endtask

  task automatic runRandom(input int inst, input int n);
    bit hold, prevHold;
    logic [7:0] d, nd;
    prevHold = 0;
    d = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      hold = (i < n - 1) && ($urandom_range(0, 1) == 1);
      nd   = 8'($urandom);
      if (!prevHold) startWord(inst, d);
      checkFrame(inst, d, hold, nd, -1);
      prevHold = hold;
      d = nd;
    end
  endtask

  initial begin
    bit idleOk;
    int n, bud;
    iRstn = 1'b0;
    valid = 3'b000;
    dataA = 8'h00; dataB = 7'h00; dataC = 8'h00;
    repeat (3) @(negedge iClk);
    checkEq("resetTx", {txA, txB, txC}, 3'b111);
    checkEq("resetReady", {readyA, readyB, readyC}, 3'b111);
    checkEq("resetBusyDone", {busyA, busyB, busyC, doneA, doneB, doneC}, 6'b0);
    iRstn  = 1'b1;
    tickEn = 1'b1;

    idleOk = 1;
    repeat (100) begin
      @(negedge iClk);
      if ({txA, txB, txC, readyA, readyB, readyC} !== 6'h3f || {doneA, doneB, doneC} !== 3'b0) idleOk = 0;
    end
    checkEq("idleTicksIgnored", idleOk, 1);

    tickFixed = 1'b1;
    startWord(0, 8'h55); checkFrame(0, 8'h55, 0, 8'h00, -1);
    tickFixed = 1'b0;

    startWord(0, 8'hA5); checkFrame(0, 8'hA5, 1, 8'h3C, -1);
    checkFrame(0, 8'h3C, 0, 8'h00, -1);

    startWord(1, 8'h07); checkFrame(1, 8'h07, 0, 8'h00, -1);
    startWord(2, 8'h07); checkFrame(2, 8'h07, 0, 8'h00, -1);
    startWord(1, 8'h03); checkFrame(1, 8'h03, 0, 8'h00, -1);
    startWord(1, 8'h7F); checkFrame(1, 8'h7F, 0, 8'h00, -1);

    startWord(0, 8'hC3); checkFrame(0, 8'hC3, 0, 8'h00, 2);

    // Reset in the middle of data bit 3 of 0x00.
    startWord(0, 8'h00);
    @(negedge iClk);
    valid[0] = 1'b0;
    n = 0; bud = 0;
    while (n < 16 + 3 * 16 + 5 && bud < 5000) begin
      @(negedge iClk);
      if (iTick16x) n++;
      bud++;
    end
    checkEq("reachedDataBit3", txA, 0);
    iRstn = 1'b0;
    #1;
    checkEq("resetTxImmediate", txA, 1);
    checkEq("resetReadyImmediate", readyA, 1);
    checkEq("resetNoDone", doneA, 0);
    repeat (3) @(negedge iClk);
    iRstn = 1'b1;
    idleOk = 1;
    repeat (40) begin
      @(negedge iClk);
      if (doneA !== 1'b0 || readyA !== 1'b1 || txA !== 1'b1) idleOk = 0;
    end
    checkEq("idleAfterReset", idleOk, 1);
    startWord(0, 8'h81); checkFrame(0, 8'h81, 0, 8'h00, -1);

    runRandom(0, 24);
    runRandom(1, 8);
    runRandom(2, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
